// File: rtl/cam_array.sv
// Word-organised content-addressable memory: every cell is compared in parallel
// against a masked key; supports addressed RAM access and a masked parallel CAM write.
module cam_array #(
   parameter int WORD_SIZE  = 8,
   parameter int CELL_QUANT = 512,
   localparam int ADDR_W    = $clog2(CELL_QUANT + 1)
) (
   input  logic                  CLK100MHZ,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     addr_in,
   input  logic [CELL_QUANT-1:0] cell_wea_ctrl_ap,
   input  logic                  sel_internal_col,
   input  logic                  cam_mode,
   input  logic [WORD_SIZE-1:0]  data_in,
   input  logic [WORD_SIZE-1:0]  key,
   input  logic [WORD_SIZE-1:0]  mask,
   input  logic                  wea,
   output logic [CELL_QUANT-1:0] tags,
   output logic [WORD_SIZE-1:0]  data_out
);

   localparam int                IDX_W   = $clog2(CELL_QUANT);
   localparam logic [ADDR_W-1:0] LIMIT_A = ADDR_W'(CELL_QUANT);

   // No handshake: a write (RAM or CAM) and a read are accepted on every clock.
   logic [WORD_SIZE-1:0] mem [CELL_QUANT];
   logic                 addr_ok;
   logic [IDX_W-1:0]     addr_idx;

   assign addr_ok  = (addr_in < LIMIT_A);
   assign addr_idx = addr_in[IDX_W-1:0];

   // Match vector reflects the contents registered before the current edge.
   always_comb begin
      tags = '0;
      for (int i = 0; i < CELL_QUANT; i++) begin
         tags[i] = (((mem[i] ^ key) & mask) == '0);
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         for (int i = 0; i < CELL_QUANT; i++) begin
            mem[i] <= '0;
         end
         data_out <= '0;
      end else begin
         // Read samples pre-edge contents, so same-cycle writes return old data.
         if (!addr_ok) begin
            data_out <= '0;
         end else if (sel_internal_col) begin
            data_out <= WORD_SIZE'(tags[addr_idx]);
         end else begin
            data_out <= mem[addr_idx];
         end

         if (cam_mode) begin
            for (int i = 0; i < CELL_QUANT; i++) begin
               if (cell_wea_ctrl_ap[i]) begin
                  mem[i] <= (mem[i] & ~mask) | (data_in & mask);
               end
            end
         end else if (wea && addr_ok) begin
            mem[addr_idx] <= data_in;
         end
      end
   end

endmodule

// File: tb/tb_cam_array.sv
// Directed bench for cam_array: reads are scoreboarded through an expected queue
// drained by a monitor one clock later; match vectors are checked directly.
module tb_cam_array;

   localparam int W  = 8;
   localparam int N  = 512;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] addr_in;
   logic [N-1:0]  cell_wea_ctrl_ap;
   logic          sel_internal_col;
   logic          cam_mode;
   logic [W-1:0]  data_in;
   logic [W-1:0]  key;
   logic [W-1:0]  mask;
   logic          wea;
   logic [N-1:0]  tags;
   logic [W-1:0]  data_out;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [W-1:0]  exp_q[$];
   logic          rd_issue = 1'b0;
   logic          rd_vld   = 1'b0;

   cam_array #(.WORD_SIZE(W), .CELL_QUANT(N)) dut (
      .CLK100MHZ        (clk),
      .rst              (rst),
      .addr_in          (addr_in),
      .cell_wea_ctrl_ap (cell_wea_ctrl_ap),
      .sel_internal_col (sel_internal_col),
      .cam_mode         (cam_mode),
      .data_in          (data_in),
      .key              (key),
      .mask             (mask),
      .wea              (wea),
      .tags             (tags),
      .data_out         (data_out)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- monitor ----------------
   always @(posedge clk) rd_vld <= rd_issue;

   always @(negedge clk) begin
      if (rd_vld) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL read_order: data_out=%02h with no expected value queued", data_out);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (data_out !== e) begin
               n_errors++;
               $display("FAIL read_data: got %02h expected %02h at %0t", data_out, e, $time);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      wea              = 1'b0;
      cam_mode         = 1'b0;
      cell_wea_ctrl_ap = '0;
      rd_issue         = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
      addr_in = a; data_in = d; wea = 1'b1; cam_mode = 1'b0;
      @(negedge clk);
      idle();
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic sel, input logic [W-1:0] e);
      addr_in = a; sel_internal_col = sel; rd_issue = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      idle();
      sel_internal_col = 1'b0;
   endtask

   task automatic rw(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] e);
      addr_in = a; data_in = d; wea = 1'b1; cam_mode = 1'b0;
      sel_internal_col = 1'b0; rd_issue = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      idle();
   endtask

   task automatic cam_wr(input logic [N-1:0] en, input logic [W-1:0] d, input logic [W-1:0] m,
                         input logic we);
      cam_mode = 1'b1; cell_wea_ctrl_ap = en; data_in = d; mask = m; wea = we;
      @(negedge clk);
      idle();
   endtask

   task automatic check_tags(input logic [W-1:0] k, input logic [W-1:0] m,
                             input logic [N-1:0] e, input string name);
      key = k; mask = m;
      #1;
      n_checks++;
      if (tags !== e) begin
         n_errors++;
         $display("FAIL %s: tags=%h expected %h", name, tags, e);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [N-1:0] ones;
      logic [N-1:0] v;
      ones = '1;
      rst = 1'b1; addr_in = '0; data_in = '0; key = '0; mask = '0;
      sel_internal_col = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      n_checks++;
      if (data_out !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_data_out: got %02h expected 00", data_out);
      end

      // Reset clears contents and wins over a simultaneous write.
      wr(10'd5, 8'hAA);
      rst = 1'b1; addr_in = 10'd7; data_in = 8'h77; wea = 1'b1;
      @(negedge clk);
      rst = 1'b0; idle();
      rd(10'd5, 1'b0, 8'h00);
      rd(10'd7, 1'b0, 8'h00);
      check_tags(8'h00, 8'hFF, ones, "reset_tags_all_one");

      // RAM write/read, including read-before-write on the same cell.
      wr(10'd0, 8'h3C);
      wr(10'd1, 8'hC3);
      wr(10'd511, 8'hFF);
      rd(10'd0, 1'b0, 8'h3C);
      rd(10'd1, 1'b0, 8'hC3);
      rd(10'd511, 1'b0, 8'hFF);
      rw(10'd0, 8'h11, 8'h3C);
      rd(10'd0, 1'b0, 8'h11);
      wr(10'd0, 8'h3C);

      // Masked match and tag read-out.
      v = '0; v[0] = 1'b1; v[511] = 1'b1;
      check_tags(8'h04, 8'h04, v, "match_bit2");
      check_tags(8'h04, 8'h00, ones, "match_mask_zero");
      key = 8'h04; mask = 8'h04;
      rd(10'd1, 1'b1, 8'h00);
      rd(10'd0, 1'b1, 8'h01);

      // CAM parallel write into cells 0 and 2.
      v = '0; v[0] = 1'b1; v[2] = 1'b1;
      cam_wr(v, 8'h81, 8'h81, 1'b0);
      v = '0; v[2] = 1'b1;
      check_tags(8'h81, 8'hFF, v, "cam_write_to_match");
      rd(10'd0, 1'b0, 8'hBD);
      rd(10'd2, 1'b0, 8'h81);
      rd(10'd1, 1'b0, 8'hC3);

      // CAM mode with no enables ignores wea; RAM mode ignores enables.
      addr_in = 10'd3;
      cam_wr('0, 8'h55, 8'hFF, 1'b1);
      rd(10'd3, 1'b0, 8'h00);
      rd(10'd0, 1'b0, 8'hBD);
      cam_mode = 1'b0; cell_wea_ctrl_ap = ones; wea = 1'b0; data_in = 8'h55; mask = 8'hFF;
      addr_in = 10'd1;
      @(negedge clk);
      idle();
      rd(10'd0, 1'b0, 8'hBD);
      rd(10'd1, 1'b0, 8'hC3);
      check_tags(8'h55, 8'hFF, '0, "no_stray_write");

      // Out-of-range address: write dropped, read returns zero.
      rw(10'd600, 8'h55, 8'h00);
      rd(10'd88, 1'b0, 8'h00);
      check_tags(8'h55, 8'hFF, '0, "oor_no_write");

      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d reads never observed, expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
